// File: rtl/corrector_error_if.sv
// Bundles the corrector's input word/syndrome/valid and its registered results.
interface corrector_error_if;
  logic       valid_in;
  logic [2:0] sindrome;
  logic [7:0] datos_recibidos;
  logic       paridad_global;
  logic [7:0] datos_corregidos;
  logic [3:0] datos_nibble;
  logic       valid_out;
  logic       err_none;
  logic       err_single;
  logic       err_double;

  modport master (
    output valid_in, sindrome, datos_recibidos, paridad_global,
    input  datos_corregidos, datos_nibble, valid_out, err_none, err_single, err_double
  );

  modport slave (
    input  valid_in, sindrome, datos_recibidos, paridad_global,
    output datos_corregidos, datos_nibble, valid_out, err_none, err_single, err_double
  );
endinterface

// File: rtl/corrector_error.sv
// SECDED Hamming(7,4)+p0 corrector: applies the detector's verdict to the received
// word and registers the corrected codeword, data nibble and error class.
module corrector_error (
  input  logic               clk,
  input  logic               rst,
  corrector_error_if.slave   bus
);

  logic [7:0] fixed;
  logic [7:0] flip_mask;
  logic [3:0] nibble;
  logic       is_none;
  logic       is_single;
  logic       is_double;

  // Syndrome 1..7 points at bit s-1; syndrome 0 with a parity mismatch means p0 (bit 7).
  always_comb begin
    flip_mask = 8'h00;
    is_none   = 1'b0;
    is_single = 1'b0;
    is_double = 1'b0;
    if (bus.paridad_global) begin
      is_single = 1'b1;
      if (bus.sindrome == 3'd0)
        flip_mask = 8'h80;
      else
        flip_mask = 8'h01 << (bus.sindrome - 3'd1);
    end else if (bus.sindrome == 3'd0) begin
      is_none = 1'b1;
    end else begin
      is_double = 1'b1;
    end
    fixed  = bus.datos_recibidos ^ flip_mask;
    nibble = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.datos_corregidos <= 8'h00;
      bus.datos_nibble     <= 4'h0;
      bus.valid_out        <= 1'b0;
      bus.err_none         <= 1'b0;
      bus.err_single       <= 1'b0;
      bus.err_double       <= 1'b0;
    end else if (bus.valid_in) begin
      bus.datos_corregidos <= fixed;
      bus.datos_nibble     <= nibble;
      bus.valid_out        <= 1'b1;
      bus.err_none         <= is_none;
      bus.err_single       <= is_single;
      bus.err_double       <= is_double;
    end else begin
      // Data holds its last value while idle; only the qualifiers drop.
      bus.valid_out  <= 1'b0;
      bus.err_none   <= 1'b0;
      bus.err_single <= 1'b0;
      bus.err_double <= 1'b0;
    end
  end

endmodule

// File: tb/tb_corrector_error.sv
// Scoreboard bench for corrector_error: directed cases, syndrome sweep, random words, reset and idle behaviour.
module tb_corrector_error;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  corrector_error_if bus ();

  corrector_error dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] word;
    logic [3:0] nib;
    logic [2:0] flags;  // {none, single, double}
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] hold_word = 8'h00;
  logic [3:0] hold_nib  = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: decide the class first, then derive the word from which bit the class blames.
  function automatic exp_t ref_model(input logic [7:0] w, input logic [2:0] s, input logic pg);
    exp_t e;
    int   bad_bit;
    e.word = w;
    if (pg == 1'b0 && s == 3'd0) begin
      e.flags = 3'b100;
    end else if (pg == 1'b1) begin
      bad_bit = (s == 3'd0) ? 7 : (int'(s) - 1);
      e.word  = w ^ 8'(1 << bad_bit);
      e.flags = 3'b010;
    end else begin
      e.flags = 3'b001;
    end
    e.nib = {e.word[6], e.word[5], e.word[4], e.word[2]};
    return e;
  endfunction

  task automatic issue(input logic [7:0] w, input logic [2:0] s, input logic pg);
    @(posedge clk);
    #1;
    bus.valid_in        = 1'b1;
    bus.datos_recibidos = w;
    bus.sindrome        = s;
    bus.paridad_global  = pg;
    q.push_back(ref_model(w, s, pg));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.valid_in        = 1'b0;
    bus.datos_recibidos = 8'($urandom);
    bus.sindrome        = 3'($urandom);
    bus.paridad_global  = 1'($urandom);
  endtask

  // Monitor: samples on the falling edge, well away from the capturing edge.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs",
            {bus.datos_corregidos, bus.datos_nibble, bus.valid_out,
             bus.err_none, bus.err_single, bus.err_double}, 32'h0);
      hold_word = 8'h00;
      hold_nib  = 4'h0;
    end else if (bus.valid_out) begin
      if (q.size() == 0) begin
        check("unexpected_valid_out", 32'(bus.valid_out), 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("datos_corregidos", 32'(bus.datos_corregidos), 32'(e.word));
        check("datos_nibble", 32'(bus.datos_nibble), 32'(e.nib));
        check("err_flags", 32'({bus.err_none, bus.err_single, bus.err_double}), 32'(e.flags));
        hold_word = e.word;
        hold_nib  = e.nib;
      end
    end else begin
      check("idle_flags", 32'({bus.err_none, bus.err_single, bus.err_double}), 32'h0);
      check("idle_hold_word", 32'(bus.datos_corregidos), 32'(hold_word));
      check("idle_hold_nib", 32'(bus.datos_nibble), 32'(hold_nib));
    end
  end

  initial begin
    bus.valid_in        = 1'b1;
    bus.datos_recibidos = 8'hA5;
    bus.sindrome        = 3'd3;
    bus.paridad_global  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    rst = 1'b0;

    issue(8'b1000_0111, 3'b000, 1'b0);
    issue(8'b1000_0110, 3'b001, 1'b1);
    issue(8'b0000_0111, 3'b000, 1'b1);
    issue(8'b1100_0110, 3'b011, 1'b0);
    idle();
    idle();

    for (int s = 1; s < 8; s++) issue(8'h87, 3'(s), 1'b1);
    idle();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else issue(8'($urandom), 3'($urandom), 1'($urandom));
    end
    idle();
    idle();

    // Reset arrives together with an in-flight word; that word must never appear.
    @(posedge clk);
    #1;
    bus.valid_in        = 1'b1;
    bus.datos_recibidos = 8'h3C;
    bus.sindrome        = 3'd5;
    bus.paridad_global  = 1'b1;
    rst = 1'b1;
    #1;
    check("async_reset_immediate",
          {bus.datos_corregidos, bus.datos_nibble, bus.valid_out,
           bus.err_none, bus.err_single, bus.err_double}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in        = 1'b1;
    bus.datos_recibidos = 8'h87;
    bus.sindrome        = 3'd4;
    bus.paridad_global  = 1'b1;
    q.push_back(ref_model(8'h87, 3'd4, 1'b1));

    for (int i = 0; i < 20; i++) issue(8'($urandom), 3'($urandom), 1'($urandom));
    idle();

    repeat (20) begin
      if (q.size() != 0) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
